// File: rtl/sram_controller_pkg.sv
// Shared definitions for the 32-to-16 bit SRAM sequencer: state encodings,
// bus widths, default base address and the byte-address to word-index mapping.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned SRAM_BASE_DEFAULT = 1024;
  localparam int          SRAM_AW           = 18;
  localparam int          SRAM_DW           = 16;
  localparam int          IDX_W             = SRAM_AW - 1;

  // Addresses below the base wrap modulo 2^17 words; no range check.
  function automatic logic [IDX_W-1:0] sram_idx(input logic [31:0] addr,
                                                input int unsigned base);
    return IDX_W'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-access wait counter: counts held cycles of one 16-bit SRAM access and
// flags the final cycle.
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit request into low/high 16-bit asynchronous SRAM accesses.
// Optional one-entry read buffer enabled by defining SRAM_READ_BUFFER_EN.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned SRAM_BASE   = SRAM_BASE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_en,
  input  logic               write_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               wr_q, wr_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               cnt_clr, cnt_en, cnt_last;
  logic               req;
  logic [IDX_W-1:0]   req_idx;
  logic               dq_oe;
  logic [SRAM_DW-1:0] dq_out;

`ifdef SRAM_READ_BUFFER_EN
  logic             buf_valid_q, buf_valid_d;
  logic [IDX_W-1:0] buf_tag_q, buf_tag_d;
  logic [31:0]      buf_data_q, buf_data_d;
`endif

  assign req     = read_en | write_en;
  assign req_idx = sram_idx(address, SRAM_BASE);

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .last(cnt_last)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
`ifdef SRAM_READ_BUFFER_EN
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (req) begin
          idx_d   = req_idx;
          wdata_d = wdata;
          wr_d    = write_en;
          state_d = LOW;
`ifdef SRAM_READ_BUFFER_EN
          if (buf_valid_q && (buf_tag_q == req_idx)) begin
            if (write_en) begin
              buf_valid_d = 1'b0;
            end else begin
              rdata_d = buf_data_q;
              state_d = DONE;
            end
          end
`endif
        end
      end
      LOW: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          if (!wr_q) rdata_d[15:0] = SRAM_DQ;
          cnt_clr = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          if (!wr_q) begin
            rdata_d[31:16] = SRAM_DQ;
`ifdef SRAM_READ_BUFFER_EN
            buf_valid_d = 1'b1;
            buf_tag_d   = idx_q;
            buf_data_d  = {SRAM_DQ, rdata_q[15:0]};
`endif
          end
          cnt_clr = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
`ifdef SRAM_READ_BUFFER_EN
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
`ifdef SRAM_READ_BUFFER_EN
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
`endif
    end
  end

  // Strobes and address decode straight from state so reset forces them idle.
  always_comb begin
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_ADDR = '0;
    dq_oe     = 1'b0;
    dq_out    = wdata_q[15:0];
    if ((state_q == LOW) || (state_q == HIGH)) begin
      SRAM_ADDR = {idx_q, (state_q == HIGH)};
      if (state_q == HIGH) dq_out = wdata_q[31:16];
      if (wr_q) begin
        SRAM_WE_N = 1'b0;
        dq_oe     = 1'b1;
      end else begin
        SRAM_OE_N = 1'b0;
      end
    end
  end

  assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DW{1'bz}};
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign rdata = rdata_q;
  assign ready = ((state_q == IDLE) && !req) || (state_q == DONE);

endmodule
